// File: rtl/m8_pkg.sv
// Shared Orbita-M8 definitions: word/address widths, default group marker,
// stream-monitor states and a saturating counter helper.
package m8_pkg;

  localparam int WORD_W = 12;
  localparam int ADDR_W = 10;

  localparam logic [WORD_W-1:0] SYNC_WORD_DEF = 12'hF2C;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } m8_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/m8_frame_monitor_if.sv
// Serial input and presented-word outputs of the M8 frame monitor.
interface m8_frame_monitor_if;
  import m8_pkg::*;

  logic              iSerial;
  logic              iBitValid;
  logic [WORD_W-1:0] oWord;
  logic              oWordValid;
  logic [ADDR_W-1:0] oWordAddr;
  logic              oGroupStart;
  logic              oLocked;
  logic [15:0]       oErrCount;

  modport master (
    output iSerial, iBitValid,
    input  oWord, oWordValid, oWordAddr, oGroupStart, oLocked, oErrCount
  );

  modport slave (
    input  iSerial, iBitValid,
    output oWord, oWordValid, oWordAddr, oGroupStart, oLocked, oErrCount
  );

endinterface

// File: rtl/m8_word_shifter.sv
// Deserializer: MSB-first shift register plus 0..11 bit counter.
// o_word_done flags the valid bit that completes a word; o_shift_next is that word.
module m8_word_shifter
  import m8_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_bit_valid,
  input  logic              i_serial,
  input  logic              i_realign,
  output logic [WORD_W-1:0] o_shift_next,
  output logic              o_word_done
);

  logic [WORD_W-1:0] r_shift;
  logic [3:0]        r_bit_cnt;
  logic [WORD_W-1:0] w_shift_next;
  logic              w_word_done;

  assign w_shift_next = {r_shift[WORD_W-2:0], i_serial};
  assign w_word_done  = i_bit_valid && (r_bit_cnt == 4'(WORD_W - 1));

  assign o_shift_next = w_shift_next;
  assign o_word_done  = w_word_done;

  // i_realign marks the marker bit found while hunting: the next bit starts word 1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (i_bit_valid) begin
      r_shift <= w_shift_next;
      if (i_realign || w_word_done) begin
        r_bit_cnt <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/m8_frame_monitor.sv
// Orbita-M8 loopback monitor: finds the group marker, holds lock, presents
// each word with its in-group address and counts bad markers seen in lock.
//   state  | meaning
//   HUNT   | compare every bit position against the marker
//   VERIFY | word-aligned, waiting for CONFIRM_GROUPS further good markers
//   LOCK   | presenting words; LOSS_LIMIT bad markers in a row return to HUNT
module m8_frame_monitor
  import m8_pkg::*;
#(
  parameter logic [WORD_W-1:0] SYNC_WORD      = SYNC_WORD_DEF,
  parameter int                GROUP_WORDS    = 1024,
  parameter int                CONFIRM_GROUPS = 2,
  parameter int                LOSS_LIMIT     = 3
) (
  input logic               clk,
  input logic               reset,
  m8_frame_monitor_if.slave bus
);

  localparam int CW = $clog2(CONFIRM_GROUPS + 1);
  localparam int MW = $clog2(LOSS_LIMIT + 1);

  m8_state_e         r_state;
  logic [ADDR_W-1:0] r_word_cnt;
  logic [CW-1:0]     r_confirm;
  logic [MW-1:0]     r_miss;
  logic [15:0]       r_err_cnt;
  logic [WORD_W-1:0] r_word;
  logic              r_word_valid;
  logic [ADDR_W-1:0] r_word_addr;
  logic              r_group_start;
  logic              r_locked;

  m8_state_e         w_state_next;
  logic [ADDR_W-1:0] w_word_cnt_next;
  logic [CW-1:0]     w_confirm_next;
  logic [MW-1:0]     w_miss_next;
  logic [15:0]       w_err_next;
  logic              w_realign;
  logic              w_present;

  logic [WORD_W-1:0] w_shift_next;
  logic              w_word_done;
  logic              w_marker_ok;
  logic [ADDR_W-1:0] w_word_cnt_inc;
  logic [CW-1:0]     w_confirm_inc;
  logic [MW-1:0]     w_miss_inc;

  m8_word_shifter u_shift (
    .clk          (clk),
    .reset        (reset),
    .i_bit_valid  (bus.iBitValid),
    .i_serial     (bus.iSerial),
    .i_realign    (w_realign),
    .o_shift_next (w_shift_next),
    .o_word_done  (w_word_done)
  );

  assign w_marker_ok    = (w_shift_next == SYNC_WORD);
  assign w_word_cnt_inc = (r_word_cnt == ADDR_W'(GROUP_WORDS - 1)) ? '0 : r_word_cnt + 1'b1;
  assign w_confirm_inc  = r_confirm + 1'b1;
  assign w_miss_inc     = r_miss + 1'b1;

  always_comb begin
    w_state_next    = r_state;
    w_word_cnt_next = r_word_cnt;
    w_confirm_next  = r_confirm;
    w_miss_next     = r_miss;
    w_err_next      = r_err_cnt;
    w_realign       = 1'b0;
    w_present       = 1'b0;
    case (r_state)
      HUNT: begin
        if (bus.iBitValid && w_marker_ok) begin
          w_state_next    = VERIFY;
          w_word_cnt_next = ADDR_W'(1);
          w_confirm_next  = '0;
          w_realign       = 1'b1;
        end
      end
      VERIFY: begin
        if (w_word_done) begin
          w_word_cnt_next = w_word_cnt_inc;
          if (r_word_cnt == '0) begin
            if (w_marker_ok) begin
              w_confirm_next = w_confirm_inc;
              // The confirming marker is itself presented as word 0 of the locked stream.
              if (w_confirm_inc == CW'(CONFIRM_GROUPS)) begin
                w_state_next = LOCK;
                w_miss_next  = '0;
                w_present    = 1'b1;
              end
            end else begin
              w_state_next = HUNT;
            end
          end
        end
      end
      LOCK: begin
        if (w_word_done) begin
          w_present       = 1'b1;
          w_word_cnt_next = w_word_cnt_inc;
          if (r_word_cnt == '0) begin
            if (w_marker_ok) begin
              w_miss_next = '0;
            end else begin
              w_miss_next = w_miss_inc;
              w_err_next  = sat_inc16(r_err_cnt);
              if (w_miss_inc == MW'(LOSS_LIMIT)) begin
                w_state_next = HUNT;
              end
            end
          end
        end
      end
      default: begin
        w_state_next = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= HUNT;
      r_word_cnt    <= '0;
      r_confirm     <= '0;
      r_miss        <= '0;
      r_err_cnt     <= '0;
      r_word        <= '0;
      r_word_valid  <= 1'b0;
      r_word_addr   <= '0;
      r_group_start <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_word_cnt    <= w_word_cnt_next;
      r_confirm     <= w_confirm_next;
      r_miss        <= w_miss_next;
      r_err_cnt     <= w_err_next;
      r_word_valid  <= w_present;
      r_group_start <= w_present && (r_word_cnt == '0);
      r_locked      <= (w_state_next == LOCK);
      if (w_present) begin
        r_word      <= w_shift_next;
        r_word_addr <= r_word_cnt;
      end
    end
  end

  assign bus.oWord       = r_word;
  assign bus.oWordValid  = r_word_valid;
  assign bus.oWordAddr   = r_word_addr;
  assign bus.oGroupStart = r_group_start;
  assign bus.oLocked     = r_locked;
  assign bus.oErrCount   = r_err_cnt;

endmodule
